// File: rtl/led_chaser.sv
// led_chaser: N_LEDS pattern generator advancing once per (period+1) enabled
// clk cycles. Supports rotate left/right, bounce (ping-pong) and binary count.
module led_chaser #(
    parameter int unsigned N_LEDS = 4,
    parameter int unsigned DIV_W  = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic [DIV_W-1:0]  period,
    output logic [N_LEDS-1:0] leds,
    output logic              tick,
    output logic              alive
);

    localparam logic [1:0] MODE_ROL    = 2'b00;
    localparam logic [1:0] MODE_ROR    = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;
    localparam logic [1:0] MODE_COUNT  = 2'b11;

    localparam logic [0:0] DIR_UP   = 1'b0;
    localparam logic [0:0] DIR_DOWN = 1'b1;

    localparam logic [N_LEDS-1:0] LEDS_RESET = N_LEDS'(1);

    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [N_LEDS-1:0] leds_q, leds_d;
    logic [0:0]        dir_q, dir_d;
    logic              tick_q, tick_d;

    logic              step;
    logic              leds_onehot;
    logic [N_LEDS-1:0] leds_rol;
    logic [N_LEDS-1:0] leds_ror;

    // Divider: step when the count reaches (or has passed) period; hold when paused
    always_comb begin
        div_cnt_d = div_cnt_q;
        step      = 1'b0;
        if (en) begin
            if (div_cnt_q >= period) begin
                div_cnt_d = '0;
                step      = 1'b1;
            end else begin
                div_cnt_d = div_cnt_q + DIV_W'(1);
            end
        end
    end

    // Pattern helpers: one-hot detect and the two rotations
    always_comb begin
        leds_onehot = (leds_q != '0) && ((leds_q & (leds_q - N_LEDS'(1))) == '0);
        leds_rol    = {leds_q[N_LEDS-2:0], leds_q[N_LEDS-1]};
        leds_ror    = {leds_q[0], leds_q[N_LEDS-1:1]};
    end

    // Next pattern and direction; shift modes recover to 0..01 if not one-hot
    always_comb begin
        leds_d = leds_q;
        dir_d  = dir_q;
        tick_d = step;
        if (step) begin
            if (mode == MODE_COUNT) begin
                leds_d = leds_q + N_LEDS'(1);
            end else if (!leds_onehot) begin
                leds_d = LEDS_RESET;
                dir_d  = DIR_UP;
            end else begin
                case (mode)
                    MODE_ROL: leds_d = leds_rol;
                    MODE_ROR: leds_d = leds_ror;
                    MODE_BOUNCE: begin
                        if (dir_q == DIR_UP && leds_q[N_LEDS-1]) begin
                            dir_d  = DIR_DOWN;
                            leds_d = leds_q >> 1;
                        end else if (dir_q == DIR_DOWN && leds_q[0]) begin
                            dir_d  = DIR_UP;
                            leds_d = leds_q << 1;
                        end else if (dir_q == DIR_UP) begin
                            leds_d = leds_q << 1;
                        end else begin
                            leds_d = leds_q >> 1;
                        end
                    end
                    default: leds_d = leds_q;
                endcase
            end
        end
    end

    // State registers with asynchronous active-high reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q <= '0;
            leds_q    <= LEDS_RESET;
            dir_q     <= DIR_UP;
            tick_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            leds_q    <= leds_d;
            dir_q     <= dir_d;
            tick_q    <= tick_d;
        end
    end

    assign leds  = leds_q;
    assign tick  = tick_q;
    assign alive = 1'b1;

endmodule

// File: tb/tb_led_chaser.sv
// tb_led_chaser: scenario tasks push expected (leds, tick) per cycle to a
// scoreboard queue and pop/compare after each clock edge.
module tb_led_chaser;

    localparam int unsigned N = 4;
    localparam int unsigned DW = 8;

    typedef struct packed {
        logic [N-1:0] leds;
        logic         tick;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [1:0]    mode;
    logic [DW-1:0] period;
    logic [N-1:0]  leds;
    logic          tick;
    logic          alive;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];

    led_chaser #(.N_LEDS(N), .DIV_W(DW)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .period(period),
        .leds(leds), .tick(tick), .alive(alive)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reset with given settings; returns at posedge+1 with rst released
    task automatic do_reset(input logic [1:0] m, input logic [DW-1:0] p);
        rst = 1'b1; en = 1'b1; mode = m; period = p;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e, got;
        rst = 1'b1; en = 1'b1; mode = 2'b00; period = DW'(3);
        #2;
        checks++;
        if (leds !== 4'b0001 || tick !== 1'b0 || alive !== 1'b1) begin
            failures++;
            $display("FAIL reset_state: leds=%b tick=%b alive=%b expected 0001 0 1", leds, tick, alive);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            e.tick = (k % 4 == 0);
            e.leds = N'(1) << ((k / 4) % 4);
            sb_q.push_back(e);
            @(posedge clk); #1;
            got = sb_q.pop_front();
            checks++;
            if (leds !== got.leds || tick !== got.tick) begin
                failures++;
                $display("FAIL rotate_left k=%0d: leds=%b tick=%b expected leds=%b tick=%b", k, leds, tick, got.leds, got.tick);
            end
        end
    endtask

    task automatic test_rotate_right();
        exp_t e, got;
        do_reset(2'b01, DW'(1));
        for (int k = 1; k <= 8; k++) begin
            e.tick = (k % 2 == 0);
            e.leds = 4'b0001;
            if (k >= 2) e.leds = 4'b1000 >> ((k / 2 - 1) % 4);
            sb_q.push_back(e);
            @(posedge clk); #1;
            got = sb_q.pop_front();
            checks++;
            if (leds !== got.leds || tick !== got.tick) begin
                failures++;
                $display("FAIL rotate_right k=%0d: leds=%b tick=%b expected leds=%b tick=%b", k, leds, tick, got.leds, got.tick);
            end
        end
    endtask

    task automatic test_bounce();
        exp_t e, got;
        logic [N-1:0] seq [7];
        seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
        do_reset(2'b10, DW'(0));
        for (int k = 0; k < 7; k++) begin
            e.leds = seq[k];
            e.tick = 1'b1;
            sb_q.push_back(e);
            @(posedge clk); #1;
            got = sb_q.pop_front();
            checks++;
            if (leds !== got.leds || tick !== got.tick) begin
                failures++;
                $display("FAIL bounce k=%0d: leds=%b tick=%b expected leds=%b tick=%b", k, leds, tick, got.leds, got.tick);
            end
        end
    endtask

    task automatic test_count_then_guard();
        exp_t e, got;
        do_reset(2'b11, DW'(0));
        for (int k = 1; k <= 20; k++) begin
            if (k == 19) mode = 2'b01;
            e.tick = 1'b1;
            if (k <= 18) e.leds = N'(k + 1);
            else if (k == 19) e.leds = 4'b0001;
            else e.leds = 4'b1000;
            sb_q.push_back(e);
            @(posedge clk); #1;
            got = sb_q.pop_front();
            checks++;
            if (leds !== got.leds || tick !== got.tick) begin
                failures++;
                $display("FAIL count_guard k=%0d: leds=%b tick=%b expected leds=%b tick=%b", k, leds, tick, got.leds, got.tick);
            end
        end
    endtask

    task automatic test_period_change();
        exp_t e, got;
        do_reset(2'b00, DW'(100));
        for (int k = 1; k <= 50; k++) begin
            e.leds = 4'b0001;
            e.tick = 1'b0;
            sb_q.push_back(e);
            @(posedge clk); #1;
            got = sb_q.pop_front();
            if (k % 10 == 0) begin
                checks++;
                if (leds !== got.leds || tick !== got.tick) begin
                    failures++;
                    $display("FAIL period_pre k=%0d: leds=%b tick=%b expected leds=%b tick=%b", k, leds, tick, got.leds, got.tick);
                end
            end
        end
        period = DW'(10);
        for (int j = 1; j <= 23; j++) begin
            e.tick = (j % 11 == 1);
            e.leds = N'(1) << ((j - 1) / 11 + 1);
            sb_q.push_back(e);
            @(posedge clk); #1;
            got = sb_q.pop_front();
            checks++;
            if (leds !== got.leds || tick !== got.tick) begin
                failures++;
                $display("FAIL period_change j=%0d: leds=%b tick=%b expected leds=%b tick=%b", j, leds, tick, got.leds, got.tick);
            end
        end
    endtask

    task automatic test_pause();
        exp_t e, got;
        do_reset(2'b00, DW'(5));
        @(posedge clk); #1;
        @(posedge clk); #1;
        en = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            e.leds = 4'b0001;
            e.tick = 1'b0;
            sb_q.push_back(e);
            @(posedge clk); #1;
            got = sb_q.pop_front();
            checks++;
            if (leds !== got.leds || tick !== got.tick) begin
                failures++;
                $display("FAIL pause k=%0d: leds=%b tick=%b expected leds=%b tick=%b", k, leds, tick, got.leds, got.tick);
            end
        end
        en = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            e.tick = (k == 4 || k == 10);
            e.leds = (k >= 10) ? 4'b0100 : ((k >= 4) ? 4'b0010 : 4'b0001);
            sb_q.push_back(e);
            @(posedge clk); #1;
            got = sb_q.pop_front();
            checks++;
            if (leds !== got.leds || tick !== got.tick) begin
                failures++;
                $display("FAIL resume k=%0d: leds=%b tick=%b expected leds=%b tick=%b", k, leds, tick, got.leds, got.tick);
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e, got;
        logic [N-1:0] seq [3];
        seq = '{4'b0010, 4'b0100, 4'b1000};
        do_reset(2'b10, DW'(0));
        repeat (4) begin
            @(posedge clk); #1;
        end
        checks++;
        if (leds !== 4'b0100) begin
            failures++;
            $display("FAIL async_pre: leds=%b expected 0100", leds);
        end
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (leds !== 4'b0001 || tick !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: leds=%b tick=%b expected leds=0001 tick=0", leds, tick);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            e.leds = seq[k];
            e.tick = 1'b1;
            sb_q.push_back(e);
            @(posedge clk); #1;
            got = sb_q.pop_front();
            checks++;
            if (leds !== got.leds || tick !== got.tick) begin
                failures++;
                $display("FAIL async_bounce k=%0d: leds=%b tick=%b expected leds=%b tick=%b", k, leds, tick, got.leds, got.tick);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rotate_right();
        test_bounce();
        test_count_then_guard();
        test_period_change();
        test_pause();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
